// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O port bridge:
// default register addresses, debounce FSM encoding and status packing.
package mips_io_pkg;

    localparam logic [31:0] DEF_PORT_OUT_ADDR = 32'h1001_0024;
    localparam logic [31:0] DEF_PORT_IN_ADDR  = 32'h1001_0028;
    localparam logic [31:0] DEF_STATUS_ADDR   = 32'h1001_002C;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } deb_state_e;

    function automatic logic [31:0] status_word(input logic overrun, input logic valid);
        return {30'b0, overrun, valid};
    endfunction

endpackage

// File: rtl/port_in_debouncer.sv
// Two-flop synchroniser plus debounce FSM for the external input byte.
// accept_o is the combinational acceptance strobe; in_event_o is its registered pulse.
module port_in_debouncer
    import mips_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_in,
    output logic [7:0] accepted_o,
    output logic       accept_o,
    output logic       in_event_o,
    output deb_state_e state_o
);

    // The capture cycle and the cycle of acceptance both observe the candidate,
    // so the counter only has to span DEBOUNCE_CYCLES-2 additional cycles.
    localparam logic [7:0] ACCEPT_AT = 8'(DEBOUNCE_CYCLES - 2);

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic       in_event_q, in_event_d;
    logic       accept;
    deb_state_e state_q, state_d;

    always_comb begin
        sync1_d = port_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != acc_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (sync2_q == acc_q) begin
                    cnt_d   = 8'd0;
                    state_d = ST_STABLE;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = 8'd0;
                end else if (cnt_q >= ACCEPT_AT) begin
                    accept  = 1'b1;
                    acc_d   = cand_q;
                    cnt_d   = 8'd0;
                    state_d = ST_STABLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
        in_event_d = accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 8'd0;
            sync2_q    <= 8'd0;
            cand_q     <= 8'd0;
            cnt_q      <= 8'd0;
            acc_q      <= 8'd0;
            in_event_q <= 1'b0;
            state_q    <= ST_STABLE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            in_event_q <= in_event_d;
            state_q    <= state_d;
        end
    end

    assign accepted_o = acc_q;
    assign accept_o   = accept;
    assign in_event_o = in_event_q;
    assign state_o    = state_q;

endmodule

// File: rtl/mmio_port_bridge.sv
// Memory-mapped I/O bridge: exact address decode, output port register,
// debounced input byte with valid/overrun status and same-cycle read data.
module mmio_port_bridge
    import mips_io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] PORT_OUT_ADDR   = DEF_PORT_OUT_ADDR,
    parameter logic [31:0] PORT_IN_ADDR    = DEF_PORT_IN_ADDR,
    parameter logic [31:0] STATUS_ADDR     = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        IOSelect,
    output logic [31:0] PortOut,
    output logic        InEvent
);

    logic        hit_out, hit_in, hit_stat;
    logic        rd_in, rd_stat;
    logic [7:0]  accepted;
    logic        accept;
    deb_state_e  deb_state;

    logic [31:0] port_out_q, port_out_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;

    port_in_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst_n      (reset),
        .port_in    (PortIn),
        .accepted_o (accepted),
        .accept_o   (accept),
        .in_event_o (InEvent),
        .state_o    (deb_state)
    );

    assign hit_out  = (Address == PORT_OUT_ADDR);
    assign hit_in   = (Address == PORT_IN_ADDR);
    assign hit_stat = (Address == STATUS_ADDR);
    assign IOSelect = hit_out | hit_in | hit_stat;
    assign rd_in    = MemRead & hit_in;
    assign rd_stat  = MemRead & hit_stat;

    // An acceptance coinciding with a PortIn read hands the new byte straight
    // over: valid stays set and it is not counted as an overrun.
    always_comb begin
        port_out_d = port_out_q;
        if (MemWrite && hit_out) port_out_d = WriteData;

        valid_d = valid_q;
        if (accept)     valid_d = 1'b1;
        else if (rd_in) valid_d = 1'b0;

        overrun_d = overrun_q;
        if (accept && valid_q && !rd_in) overrun_d = 1'b1;
        else if (rd_stat)                overrun_d = 1'b0;
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRead) begin
            if (hit_out)       ReadData = port_out_q;
            else if (hit_in)   ReadData = {24'd0, accepted};
            else if (hit_stat) ReadData = status_word(overrun_q, valid_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= 32'd0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign PortOut = port_out_q;

    a_event_from_stable: assert property (@(posedge clk) disable iff (!reset)
        InEvent |-> (deb_state == ST_STABLE));

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Directed bench for mmio_port_bridge: decode/write table plus debounce,
// overrun, collision and reset sequences.
module tb_mmio_port_bridge;

  localparam logic [31:0] A_OUT  = 32'h1001_0024;
  localparam logic [31:0] A_IN   = 32'h1001_0028;
  localparam logic [31:0] A_STAT = 32'h1001_002C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        IOSelect;
  logic [31:0] PortOut;
  logic        InEvent;

  int n_vec = 0;
  int n_bad = 0;

  mmio_port_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .IOSelect  (IOSelect),
    .PortOut   (PortOut),
    .InEvent   (InEvent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mw;
    logic        mr;
    logic [31:0] exp_rd;
    logic        exp_sel;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    check(name, ReadData, exp);
    step();
    idle();
  endtask

  // Steps until InEvent is seen or the bound expires; n = edges taken.
  task automatic wait_event(input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (InEvent) break;
    end
  endtask

  initial begin
    int n;
    int seen;

    tbl[0]  = '{A_OUT,         32'hDEAD_BEEF, 1, 0, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[1]  = '{A_OUT,         32'h0,         0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    tbl[2]  = '{A_IN,          32'h1234_5678, 1, 0, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[3]  = '{A_STAT,        32'hFFFF_FFFF, 1, 0, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[4]  = '{A_STAT,        32'h0,         0, 1, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[5]  = '{A_IN,          32'h0,         0, 1, 32'h0,         1, 32'hDEAD_BEEF};
    tbl[6]  = '{32'h1001_0020, 32'h5555_5555, 1, 0, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[7]  = '{32'h1001_0025, 32'h0,         0, 1, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[8]  = '{A_OUT,         32'h0000_00A5, 1, 1, 32'hDEAD_BEEF, 1, 32'h0000_00A5};
    tbl[9]  = '{A_OUT,         32'h0,         0, 1, 32'h0000_00A5, 1, 32'h0000_00A5};
    tbl[10] = '{A_OUT,         32'h0,         0, 0, 32'h0,         1, 32'h0000_00A5};

    // Reset state
    #1;
    check("rst_portout", PortOut, 32'h0);
    check("rst_inevent", {31'd0, InEvent}, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();

    // Decode / write table
    for (int i = 0; i < 11; i++) begin
      Address = tbl[i].addr; WriteData = tbl[i].wdata;
      MemWrite = tbl[i].mw; MemRead = tbl[i].mr;
      #1;
      check($sformatf("tbl%0d_rdata", i), ReadData, tbl[i].exp_rd);
      check($sformatf("tbl%0d_iosel", i), {31'd0, IOSelect}, {31'd0, tbl[i].exp_sel});
      step();
      idle();
      check($sformatf("tbl%0d_portout", i), PortOut, tbl[i].exp_out);
    end

    // Bounce: 5A/00 every 2 cycles, never accepted
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      PortIn = (i % 4 < 2) ? 8'h5A : 8'h00;
      step();
      if (InEvent) seen++;
    end
    PortIn = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      if (InEvent) seen++;
    end
    check("bounce_events", seen, 0);
    read_check("bounce_in", A_IN, 32'h0);
    read_check("bounce_stat", A_STAT, 32'h0);

    // Accept 00 -> 5A: InEvent after 6 edges, single-cycle pulse
    PortIn = 8'h5A;
    wait_event(20, n);
    check("acc_latency", n, 6);
    step();
    check("acc_pulse_end", {31'd0, InEvent}, 32'h0);
    read_check("acc_stat1", A_STAT, 32'h1);
    read_check("acc_in", A_IN, 32'h5A);
    read_check("acc_stat0", A_STAT, 32'h0);

    // Overrun
    PortIn = 8'h11;
    wait_event(20, n);
    check("ovr_lat11", n, 6);
    PortIn = 8'h22;
    wait_event(20, n);
    check("ovr_lat22", n, 6);
    read_check("ovr_stat3", A_STAT, 32'h3);
    read_check("ovr_stat1", A_STAT, 32'h1);
    read_check("ovr_in", A_IN, 32'h22);
    read_check("ovr_stat0", A_STAT, 32'h0);

    // Collision: valid=1 (byte 44), PortIn read lands on the 33 acceptance cycle
    PortIn = 8'h44;
    wait_event(20, n);
    check("col_lat44", n, 6);
    PortIn = 8'h33;
    repeat (5) step();
    check("col_pre_event", {31'd0, InEvent}, 32'h0);
    Address = A_IN; MemRead = 1'b1;
    #1;
    check("col_in_old", ReadData, 32'h44);
    step();
    idle();
    check("col_event", {31'd0, InEvent}, 32'h1);
    read_check("col_stat", A_STAT, 32'h1);
    read_check("col_in_new", A_IN, 32'h33);

    // Reset mid-SETTLING (count 2) with 77 held
    PortIn = 8'h77;
    repeat (5) step();
    reset = 1'b0;
    Address = A_IN; MemRead = 1'b1;
    #1;
    check("rstm_portout", PortOut, 32'h0);
    check("rstm_rdata", ReadData, 32'h0);
    check("rstm_inevent", {31'd0, InEvent}, 32'h0);
    idle();
    step();
    reset = 1'b1;
    wait_event(20, n);
    check("rstm_latency", n, 6);
    read_check("rstm_in", A_IN, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_port_bridge.md
MMIO_PORT_BRIDGE -- requirements
Module: mmio_port_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronised PortIn value must hold before acceptance; range 2..255.
REQ-002 Parameter PORT_OUT_ADDR, default 32'h1001_0024: write/read address of the output register.
REQ-003 Parameter PORT_IN_ADDR, default 32'h1001_0028: read address of the accepted input byte.
REQ-004 Parameter STATUS_ADDR, default 32'h1001_002C: read address of the status word.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Address  input  32  processor ALU result used as data address.
REQ-008 WriteData  input  32  processor rs2 read data.
REQ-009 MemWrite  input  1  processor store strobe.
REQ-010 MemRead  input  1  processor load strobe.
REQ-011 PortIn  input  8  asynchronous external switches.
REQ-012 ReadData  output  32  read data returned to the write-back mux.
REQ-013 IOSelect  output  1  high when Address equals any of the three decoded addresses; steers write-back away from DataMemory.
REQ-014 PortOut  output  32  registered external output port.
REQ-015 InEvent  output  1  one-cycle pulse when a new input byte is accepted.

Function
REQ-016 Address decode SHALL be an exact 32-bit compare; other addresses SHALL produce IOSelect=0, ReadData=0, and no state change.
REQ-017 MemWrite with Address=PORT_OUT_ADDR SHALL load WriteData into PortOut at the next rising edge (1-cycle latency).
REQ-018 Writes to PORT_IN_ADDR or STATUS_ADDR SHALL be ignored.
REQ-019 Reads SHALL be combinational, in the same cycle as MemRead: PORT_OUT_ADDR -> PortOut; PORT_IN_ADDR -> {24'b0, accepted byte}; STATUS_ADDR -> {30'b0, overrun, valid}.
REQ-020 PortIn SHALL pass through a two-flop synchroniser before any other use.
REQ-021 Debounce FSM states: STABLE and SETTLING.
REQ-022 STABLE: on a synchronised value different from the accepted byte, the FSM SHALL capture it as candidate, clear the counter, and enter SETTLING.
REQ-023 SETTLING: while the synchronised value equals the candidate, the counter SHALL increment; a different value SHALL recapture the candidate and clear the counter; a value equal to the accepted byte SHALL return the FSM to STABLE without acceptance.
REQ-024 When the candidate has held DEBOUNCE_CYCLES consecutive cycles, the candidate SHALL become the accepted byte, InEvent SHALL pulse for one cycle, valid SHALL set, and the FSM SHALL return to STABLE.
REQ-025 Total latency from a PortIn change to InEvent SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-026 The counter SHALL be 8 bits wide and SHALL never wrap.
REQ-027 MemRead at PORT_IN_ADDR SHALL clear valid at the next edge.
REQ-028 MemRead at STATUS_ADDR SHALL clear overrun at the next edge.
REQ-029 Acceptance while valid=1 SHALL set overrun.
REQ-030 Acceptance in the same cycle as a valid-clearing read SHALL leave valid=1 and SHALL NOT set overrun.
REQ-031 Simultaneous MemRead and MemWrite SHALL perform both actions.

Reset
REQ-032 reset low SHALL immediately force: PortOut=0, accepted byte=0, candidate=0, synchroniser flops=0, counter=0, valid=0, overrun=0, InEvent=0, FSM=STABLE.
REQ-033 Reset asserted mid-SETTLING SHALL discard the candidate; after release, a held non-zero PortIn SHALL be accepted 2 + DEBOUNCE_CYCLES cycles later.

Structure
REQ-034 The three default addresses and the FSM state encoding SHALL reside in a shared package, mips_io_pkg.
REQ-035 The synchroniser and debounce FSM SHALL form one sub-module, port_in_debouncer; decode and registers SHALL stay in the top.

Verification
REQ-036 Write: MemWrite=1, Address=1001_0024, WriteData=DEAD_BEEF -> PortOut=DEAD_BEEF the next cycle; IOSelect=1 during the write.
REQ-037 Accept: PortIn 00->5A held -> InEvent pulses 6 cycles later; status read returns 1; PortIn read returns 5A; the following status read returns 0.
REQ-038 Bounce: PortIn alternates 5A/00 every 2 cycles for 20 cycles, then 00 -> no InEvent and accepted byte stays 00.
REQ-039 Overrun: accept 11, then accept 22 without reading -> status=3; a status read clears overrun (status=1); a PortIn read returns 22.
REQ-040 Collision: PortIn read asserted in the acceptance cycle -> valid stays 1; overrun stays 0.
REQ-041 Reset: reset pulsed low for 1 cycle at SETTLING count 2 with PortIn=77 held -> all outputs 0 immediately; InEvent 6 cycles after release.
